// File: rtl/rv_lsu.sv
// rv_lsu: RV32I load/store unit in front of a single-port word SRAM without byte enables.
// Sub-word stores are read-modify-write; one request in flight, exactly one response per request.
module rv_lsu #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 10
) (
    input  logic               i_lsu_clk,
    input  logic               i_lsu_rst,
    input  logic               i_lsu_req_val,
    output logic               o_lsu_req_rdy,
    input  logic               i_lsu_req_we,
    input  logic [2:0]         i_lsu_req_funct3,
    input  logic [31:0]        i_lsu_req_addr,
    input  logic [31:0]        i_lsu_req_wdata,
    output logic               o_lsu_rsp_val,
    input  logic               i_lsu_rsp_rdy,
    output logic [31:0]        o_lsu_rsp_rdata,
    output logic               o_lsu_rsp_err,
    output logic [BW_ADDR-1:0] o_lsu_sram_addr,
    output logic [BW_DATA-1:0] o_lsu_sram_data,
    output logic               o_lsu_sram_cen,
    output logic               o_lsu_sram_wen,
    output logic               o_lsu_sram_ren,
    input  logic [BW_DATA-1:0] i_lsu_sram_data,
    input  logic               i_lsu_sram_data_val
);
    localparam int AW = BW_ADDR + 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [AW-1:0]   addr_q;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [31:0]     wdata_q;
    logic            err_q;
    logic [31:0]     result_q;
    logic            accept;
    logic            rsp_done;
    logic            req_err;
    logic [AW-1:0]   cur_addr;
    logic [31:0]     wr_word;

    function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic misalign;
        logic out_of_range;
        logic illegal;
        misalign     = ((f3[1:0] == 2'b01) && addr[0]) ||
                       ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        out_of_range = |addr[31:AW];
        if (we) begin
            illegal = (f3 >= 3'b011);
        end else begin
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return misalign | out_of_range | illegal;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h000000, b};
            3'b101:  return {16'h0000, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] m;
        m = word;
        case (f3[1:0])
            2'b00:   m[{off, 3'b000} +: 8]        = wdata[7:0];
            2'b01:   m[{off[1], 4'b0000} +: 16]   = wdata[15:0];
            default: m = wdata;
        endcase
        return m;
    endfunction

    assign accept   = i_lsu_req_val & o_lsu_req_rdy;
    assign rsp_done = o_lsu_rsp_val & i_lsu_rsp_rdy;
    assign req_err  = req_error(i_lsu_req_we, i_lsu_req_funct3, i_lsu_req_addr);

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!accept) begin
                    next_state = IDLE;
                end else if (req_err) begin
                    next_state = RESP;
                end else if (i_lsu_req_we && (i_lsu_req_funct3 == 3'b010)) begin
                    next_state = WR;
                end else begin
                    next_state = RD;
                end
            end
            RD: begin
                if (!i_lsu_sram_data_val) begin
                    next_state = RD;
                end else if (we_q) begin
                    next_state = WR;
                end else begin
                    next_state = RESP;
                end
            end
            WR:      next_state = RESP;
            RESP: begin
                if (rsp_done) begin
                    next_state = IDLE;
                end else begin
                    next_state = RESP;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // SRAM address and write word for the cycle being entered; IDLE uses the live request.
    always_comb begin
        cur_addr = addr_q;
        wr_word  = 32'h00000000;
        if (state == IDLE) begin
            cur_addr = i_lsu_req_addr[AW-1:0];
            wr_word  = i_lsu_req_wdata;
        end else if (state == RD) begin
            wr_word  = merge_store(i_lsu_sram_data, wdata_q, addr_q[1:0], f3_q);
        end else begin
            wr_word  = 32'h00000000;
        end
    end

    // State register.
    always_ff @(posedge i_lsu_clk or posedge i_lsu_rst) begin
        if (i_lsu_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request latch and load result.
    always_ff @(posedge i_lsu_clk or posedge i_lsu_rst) begin
        if (i_lsu_rst) begin
            addr_q   <= {AW{1'b0}};
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            wdata_q  <= 32'h00000000;
            err_q    <= 1'b0;
            result_q <= 32'h00000000;
        end else if (accept) begin
            addr_q   <= i_lsu_req_addr[AW-1:0];
            we_q     <= i_lsu_req_we;
            f3_q     <= i_lsu_req_funct3;
            wdata_q  <= i_lsu_req_wdata;
            err_q    <= req_err;
            result_q <= 32'h00000000;
        end else if ((state == RD) && i_lsu_sram_data_val && !we_q) begin
            result_q <= load_extend(i_lsu_sram_data, addr_q[1:0], f3_q);
        end
    end

    // Registered outputs: SRAM strobes follow the state being entered, the response lags RESP by one cycle.
    always_ff @(posedge i_lsu_clk or posedge i_lsu_rst) begin
        if (i_lsu_rst) begin
            o_lsu_req_rdy   <= 1'b0;
            o_lsu_sram_cen  <= 1'b0;
            o_lsu_sram_ren  <= 1'b0;
            o_lsu_sram_wen  <= 1'b0;
            o_lsu_sram_addr <= {BW_ADDR{1'b0}};
            o_lsu_sram_data <= {BW_DATA{1'b0}};
            o_lsu_rsp_val   <= 1'b0;
            o_lsu_rsp_rdata <= 32'h00000000;
            o_lsu_rsp_err   <= 1'b0;
        end else begin
            o_lsu_req_rdy   <= (next_state == IDLE);
            o_lsu_sram_cen  <= (next_state == RD) || (next_state == WR);
            o_lsu_sram_ren  <= (next_state == RD);
            o_lsu_sram_wen  <= (next_state == WR);
            o_lsu_sram_addr <= ((next_state == RD) || (next_state == WR)) ? cur_addr[AW-1:2]
                                                                           : {BW_ADDR{1'b0}};
            o_lsu_sram_data <= (next_state == WR) ? wr_word : {BW_DATA{1'b0}};
            o_lsu_rsp_val   <= (state == RESP) && !rsp_done;
            o_lsu_rsp_rdata <= ((state == RESP) && !rsp_done) ? result_q : 32'h00000000;
            o_lsu_rsp_err   <= (state == RESP) && !rsp_done && err_q;
        end
    end
endmodule
